// File: rtl/riscv_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Holds the arbiter FSM state encoding and the default widths and timeout.
package riscv_pkg;

    localparam int DEFAULT_AW      = 32;
    localparam int DEFAULT_DW      = 32;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection between the fetch (I) and load/store (D) requesters.
// ARB_RR_EN selects round-robin on ptr; otherwise D has fixed priority.
module arb_pick2 (
    input  logic i_req,
    input  logic d_req,
    input  logic ptr,
    output logic sel_d
);

`ifdef ARB_RR_EN
    // ptr=0 favours D, ptr=1 favours I; only matters on a simultaneous request.
    assign sel_d = d_req && (!i_req || !ptr);
`else
    logic unused_ptr;
    assign unused_ptr = ptr;
    assign sel_d      = d_req;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port memory,
// one transaction at a time, with a response timeout. Define ARB_RR_EN for round-robin.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [7:0]      tmo_cnt;
    logic            tmo_hit;
    logic            grant;
    logic            sel_d;
    logic            ptr;

    logic            cmd_d;
    logic            cmd_we;
    logic [DW/8-1:0] cmd_be;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;

    assign grant   = (state == IDLE) && (i_req || d_req);
    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

    arb_pick2 u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .ptr   (ptr),
        .sel_d (sel_d)
    );

`ifdef ARB_RR_EN
    // After every grant, point at the requester that just lost the turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant) begin
            ptr <= sel_d;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    // NOTE: every variable in this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE:  if (i_req || d_req) state_nxt = ISSUE;
            ISSUE: begin
                mem_req   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (mem_ack || tmo_hit) state_nxt = RESP;
            RESP: begin
                i_ack     = !cmd_d;
                d_ack     = cmd_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we    = cmd_we;
    assign mem_be    = cmd_be;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            cmd_d     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_be    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (grant) begin
                cmd_d     <= sel_d;
                cmd_we    <= sel_d ? d_we    : 1'b0;
                cmd_be    <= sel_d ? d_be    : '1;
                cmd_addr  <= sel_d ? d_addr  : i_addr;
                cmd_wdata <= sel_d ? d_wdata : '0;
            end

            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            // A real ack wins over a timeout landing in the same cycle.
            if (state == WAIT && (mem_ack || tmo_hit)) begin
                if (cmd_d) begin
                    if (mem_ack) begin
                        if (!cmd_we) d_rdata <= mem_rdata;
                        d_err <= 1'b0;
                    end else begin
                        d_rdata <= '0;
                        d_err   <= 1'b1;
                    end
                end else begin
                    i_rdata <= mem_ack ? mem_rdata : '0;
                    i_err   <= !mem_ack;
                end
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 15: maximum WAIT cycles without mem_ack before an error response; legal range 1..255.
REQ-004 clk  in  1: single clock; all state changes on the rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 i_req in 1 / i_addr in AW: fetch requester; read-only.
REQ-007 i_ack out 1 / i_rdata out DW / i_err out 1: fetch response.
REQ-008 d_req in 1 / d_we in 1 / d_be in DW/8 / d_addr in AW / d_wdata in DW: load/store requester.
REQ-009 d_ack out 1 / d_rdata out DW / d_err out 1: load/store response.
REQ-010 mem_req out 1 / mem_we out 1 / mem_be out DW/8 / mem_addr out AW / mem_wdata out DW: shared single-port memory command.
REQ-011 mem_ack in 1 / mem_rdata in DW: memory completion; mem_rdata is valid when mem_ack=1.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-013 IDLE: if any req=1, latch the winner's command at the edge and go to ISSUE; otherwise stay.
REQ-014 ISSUE: mem_req=1 for exactly one cycle with the latched command; next state WAIT.
REQ-015 mem_ack is ignored outside WAIT.
REQ-016 WAIT: mem_ack=1 -> latch mem_rdata (reads only), go to RESP.
REQ-017 WAIT: no ack for TIMEOUT consecutive cycles -> go to RESP with err=1 and rdata=0.
REQ-018 RESP: winner's ack=1 for exactly one cycle, plus rdata and err; both requesters' req are ignored; next state IDLE.
REQ-019 Requester holds req and command stable from assertion until its ack cycle.
REQ-020 Response latency: req seen in IDLE at cycle T -> mem_req at T+1 -> ack at (cycle of mem_ack)+1; minimum T+3.
REQ-021 For a fetch, mem_we=0 and mem_be=all ones; i_* never issues a write.
REQ-022 rdata and err hold their value until the next RESP; ack is never asserted to both requesters in the same cycle.
REQ-023 mem_* outputs other than mem_req are don't-care when mem_req=0 but are driven with the latched command.
REQ-024 Timeout counter is 8 bits, cleared on entering WAIT; TIMEOUT=1 errors after one ack-less WAIT cycle.

Reset
REQ-025 rst=1 at an edge forces IDLE, clears the counter and the round-robin pointer (favour D next), and sets every output to 0 (rdata=0, err=0), including mid-transaction.
REQ-026 A transaction aborted by reset produces no ack; a late mem_ack after reset is ignored.

Configuration
REQ-027 ARB_RR_EN defined: when both reqs are high in IDLE, the grant alternates, and a 1-bit pointer toggles to the other requester after each grant.
REQ-028 ARB_RR_EN undefined: fixed priority, D always wins a simultaneous request; no pointer register exists.

Structure
REQ-029 riscv_pkg holds the arb_state_t enum (IDLE/ISSUE/WAIT/RESP), the default address and data width constants, and the DEFAULT_TIMEOUT constant.
REQ-030 Winner selection lives in sub-module arb_pick2 (inputs i_req, d_req, ptr; output sel_d), and contains the ARB_RR_EN conditional.

Verification
REQ-031 Single fetch: i_req=1, i_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_req at T+1, i_ack at T+4, i_rdata=0x00500093, i_err=0.
REQ-032 Store: d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0x0000ABCD -> mem_we=1, mem_be=4'b0011, mem_wdata=0x0000ABCD in the ISSUE cycle; d_ack one cycle after mem_ack.
REQ-033 Contention: i_req and d_req held high for 4 transactions -> with ARB_RR_EN the grant order is D,I,D,I; without it the order is D,D,D,D and i_ack stays 0.
REQ-034 Timeout: d_req read, mem_ack never asserted, TIMEOUT=15 -> d_ack with d_err=1 and d_rdata=0 exactly 15 cycles after entering WAIT.
REQ-035 Reset mid-WAIT: rst=1 for one cycle, then mem_ack=1 -> no ack on either port, state IDLE, all outputs 0.
REQ-036 Back-to-back: i_req held high through i_ack with a new i_addr=0x104 -> exactly one mem_req per ack and no duplicate issue of 0x100.
